pc_unit: RTL and testbench

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_pkg.sv | 30 +++
 rtl/pc_incr.sv | 20 ++
 rtl/pc_unit.sv | 168 ++++++++++++++++
 tb/tb_pc_unit.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// -----------------------------------------------------------------------------
// pc_pkg
// Shared definitions for the program-counter unit:
//   - pc_state_e   : fetch FSM state encoding (BOOT, RUN, TRAP, HALT)
//   - PC_RESET_VEC : default first fetch address after reset
//   - PC_TRAP_VEC  : default address loaded on a trap or misaligned redirect
//   - PC_INC       : default sequential fetch increment in bytes
//   - PC_CNT_W     : default width of the accepted-fetch counter
//   - pc_is_misaligned() : word-alignment check on a redirect target
// -----------------------------------------------------------------------------
package pc_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_TRAP = 2'd2,
    ST_HALT = 2'd3
  } pc_state_e;

  localparam logic [31:0] PC_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] PC_TRAP_VEC  = 32'h0000_0100;
  localparam int unsigned PC_INC       = 32'd4;
  localparam int unsigned PC_CNT_W     = 32'd32;

  // A fetch target must be word aligned; any set bit in [1:0] is rejected.
  function automatic logic pc_is_misaligned(input logic [1:0] i_lsb);
    return (i_lsb != 2'b00);
  endfunction

endpackage : pc_pkg

// File: rtl/pc_incr.sv
// -----------------------------------------------------------------------------
// pc_incr
// Combinational sequential-PC adder: o_sum = i_a + INC, wrapping modulo
// 2^XLEN with no carry out.
// Ports:
//   i_a   [XLEN-1:0] : current program counter
//   o_sum [XLEN-1:0] : next sequential program counter
// -----------------------------------------------------------------------------
module pc_incr #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned INC  = 4
) (
  input  logic [XLEN-1:0] i_a,
  output logic [XLEN-1:0] o_sum
);

  // Carry out of the top bit is intentionally discarded so the PC wraps to 0.
  assign o_sum = i_a + XLEN'(INC);

endmodule : pc_incr

// File: rtl/pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit
// Program-counter / fetch-request generator with a four-state FSM
// (BOOT, RUN, TRAP, HALT). Next-PC priority in RUN is
// trap_req > redirect > halt_req > sequential increment > hold.
// Ports:
//   clk             : sole clock, all state updates on the rising edge
//   reset           : synchronous active-high reset, dominates all inputs
//   fetch_ready     : fetch stage accepts pc this cycle
//   redirect        : branch/jump taken this cycle
//   redirect_target : branch/jump destination (must be word aligned)
//   trap_req        : exception, forces pc to TRAP_VEC
//   halt_req        : stop fetching after the current cycle
//   pc              : current fetch address
//   pc_valid        : pc is a valid fetch request
//   misaligned      : one-cycle pulse after a rejected misaligned redirect
//   halted          : unit is in HALT
//   fetch_count     : number of accepted fetches (pc_valid && fetch_ready)
// -----------------------------------------------------------------------------
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(PC_RESET_VEC),
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(PC_TRAP_VEC),
  parameter int unsigned     INC       = PC_INC,
  parameter int unsigned     CNT_W     = PC_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fetch_ready,
  input  logic             redirect,
  input  logic [XLEN-1:0]  redirect_target,
  input  logic             trap_req,
  input  logic             halt_req,
  output logic [XLEN-1:0]  pc,
  output logic             pc_valid,
  output logic             misaligned,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_count
);

  pc_state_e        r_state;
  logic [XLEN-1:0]  r_pc;
  logic             r_pc_valid;
  logic             r_misaligned;
  logic             r_halted;
  logic [CNT_W-1:0] r_fetch_count;

  pc_state_e        w_state_nxt;
  logic [XLEN-1:0]  w_pc_nxt;
  logic             w_misaligned_nxt;
  logic [XLEN-1:0]  w_pc_inc;
  logic             w_target_bad;

  pc_incr #(
    .XLEN (XLEN),
    .INC  (INC)
  ) u_pc_incr (
    .i_a   (r_pc),
    .o_sum (w_pc_inc)
  );

  assign w_target_bad = pc_is_misaligned(redirect_target[1:0]);

  // Next-state / next-PC selection for the fetch FSM.
  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_misaligned_nxt = 1'b0;
    case (r_state)
      ST_BOOT: begin
        // BOOT ignores every request and always spends exactly one cycle.
        w_state_nxt = ST_RUN;
        w_pc_nxt    = RESET_VEC;
      end
      ST_RUN: begin
        if (trap_req) begin
          w_state_nxt = ST_TRAP;
          w_pc_nxt    = TRAP_VEC;
        end else if (redirect) begin
          // The current pc is dropped even when fetch_ready is low.
          if (w_target_bad) begin
            w_state_nxt      = ST_TRAP;
            w_pc_nxt         = TRAP_VEC;
            w_misaligned_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_RUN;
            w_pc_nxt    = redirect_target;
          end
        end else if (halt_req) begin
          w_state_nxt = ST_HALT;
          w_pc_nxt    = r_pc;
        end else if (fetch_ready) begin
          w_state_nxt = ST_RUN;
          w_pc_nxt    = w_pc_inc;
        end else begin
          w_state_nxt = ST_RUN;
          w_pc_nxt    = r_pc;
        end
      end
      ST_TRAP: begin
        // TRAP shows TRAP_VEC as invalid for one cycle; a repeated trap re-enters it.
        w_pc_nxt = TRAP_VEC;
        if (trap_req) begin
          w_state_nxt = ST_TRAP;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_HALT: begin
        // halt_req is irrelevant here; only a trap or redirect leaves HALT.
        if (trap_req) begin
          w_state_nxt = ST_TRAP;
          w_pc_nxt    = TRAP_VEC;
        end else if (redirect) begin
          if (w_target_bad) begin
            w_state_nxt      = ST_TRAP;
            w_pc_nxt         = TRAP_VEC;
            w_misaligned_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_RUN;
            w_pc_nxt    = redirect_target;
          end
        end else begin
          w_state_nxt = ST_HALT;
          w_pc_nxt    = r_pc;
        end
      end
      default: begin
        w_state_nxt = ST_BOOT;
        w_pc_nxt    = RESET_VEC;
      end
    endcase
  end

  // All unit state, with outputs registered from the next state so they
  // line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_BOOT;
      r_pc          <= RESET_VEC;
      r_pc_valid    <= 1'b0;
      r_misaligned  <= 1'b0;
      r_halted      <= 1'b0;
      r_fetch_count <= {CNT_W{1'b0}};
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_pc_valid   <= (w_state_nxt == ST_RUN);
      r_misaligned <= w_misaligned_nxt;
      r_halted     <= (w_state_nxt == ST_HALT);
      // Count the handshake on the pc being presented now, not the next one.
      if (r_pc_valid && fetch_ready) begin
        r_fetch_count <= r_fetch_count + CNT_W'(1);
      end else begin
        r_fetch_count <= r_fetch_count;
      end
    end
  end

  assign pc          = r_pc;
  assign pc_valid    = r_pc_valid;
  assign misaligned  = r_misaligned;
  assign halted      = r_halted;
  assign fetch_count = r_fetch_count;

endmodule : pc_unit

// File: tb/tb_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_unit
// Directed, table-driven bench for pc_unit: each record holds the inputs
// applied before a rising edge and the outputs expected just after it,
// followed by hand-written sequences for reset-in-trap, BOOT ignoring a
// trap and a misaligned redirect out of HALT.
// -----------------------------------------------------------------------------
module tb_pc_unit;

  logic        clk;
  logic        reset;
  logic        fetch_ready;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        trap_req;
  logic        halt_req;
  logic [31:0] pc;
  logic        pc_valid;
  logic        misaligned;
  logic        halted;
  logic [31:0] fetch_count;

  int n_checks;
  int n_fail;

  typedef struct {
    logic        rst;
    logic        fr;
    logic        rd;
    logic [31:0] tgt;
    logic        trap;
    logic        halt;
    logic [31:0] e_pc;
    logic        e_v;
    logic        e_mis;
    logic        e_halt;
    logic [31:0] e_cnt;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];

  pc_unit dut (
    .clk             (clk),
    .reset           (reset),
    .fetch_ready     (fetch_ready),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .trap_req        (trap_req),
    .halt_req        (halt_req),
    .pc              (pc),
    .pc_valid        (pc_valid),
    .misaligned      (misaligned),
    .halted          (halted),
    .fetch_count     (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got 0x%08h expected 0x%08h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic fr, input logic rd, input logic [31:0] tgt,
                       input logic trap, input logic halt);
    reset           = rst;
    fetch_ready     = fr;
    redirect        = rd;
    redirect_target = tgt;
    trap_req        = trap;
    halt_req        = halt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input int idx, input logic [31:0] e_pc, input logic e_v, input logic e_mis,
                         input logic e_halt, input logic [31:0] e_cnt);
    chk("pc", idx, pc, e_pc);
    chk("pc_valid", idx, {31'd0, pc_valid}, {31'd0, e_v});
    chk("misaligned", idx, {31'd0, misaligned}, {31'd0, e_mis});
    chk("halted", idx, {31'd0, halted}, {31'd0, e_halt});
    chk("fetch_count", idx, fetch_count, e_cnt);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

    //            rst   fr    rd    tgt            trap  halt  e_pc           e_v   e_mis e_hlt e_cnt
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'd0}; // reset -> BOOT
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'd0}; // BOOT -> RUN
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0004, 1'b1, 1'b0, 1'b0, 32'd1};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0008, 1'b1, 1'b0, 1'b0, 32'd2};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_000C, 1'b1, 1'b0, 1'b0, 32'd3};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0010, 1'b1, 1'b0, 1'b0, 32'd4}; // 4 accepted
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 32'h0000_0008, 1'b0, 1'b0, 32'h0000_0008, 1'b1, 1'b0, 1'b0, 32'd4}; // back to 8
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0008, 1'b1, 1'b0, 1'b0, 32'd4}; // stall
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0008, 1'b1, 1'b0, 1'b0, 32'd4};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0008, 1'b1, 1'b0, 1'b0, 32'd4};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 32'h0000_0040, 1'b0, 1'b0, 32'h0000_0040, 1'b1, 1'b0, 1'b0, 32'd4}; // redirect, not ready
    vecs[11] = '{1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0044, 1'b1, 1'b0, 1'b0, 32'd5};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 32'h0000_0042, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b1, 1'b0, 32'd6}; // misaligned
    vecs[13] = '{1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0100, 1'b1, 1'b0, 1'b0, 32'd6};
    vecs[14] = '{1'b0, 1'b1, 1'b1, 32'h0000_0200, 1'b1, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 32'd7}; // trap beats redirect
    vecs[15] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0100, 1'b1, 1'b0, 1'b0, 32'd7};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b1, 32'd7}; // halt
    vecs[17] = '{1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b1, 32'd7}; // stays halted
    vecs[18] = '{1'b0, 1'b0, 1'b1, 32'h0000_0080, 1'b0, 1'b0, 32'h0000_0080, 1'b1, 1'b0, 1'b0, 32'd7}; // leave HALT
    vecs[19] = '{1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 32'd7};
    vecs[20] = '{1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'd8}; // wrap
    vecs[21] = '{1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0004, 1'b1, 1'b0, 1'b0, 32'd9};
    vecs[22] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0004, 1'b0, 1'b0, 1'b1, 32'd9}; // halt at 4
    vecs[23] = '{1'b1, 1'b1, 1'b1, 32'h0000_0080, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'd0}; // reset in HALT
    vecs[24] = '{1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'd0}; // BOOT -> RUN

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].fr, vecs[i].rd, vecs[i].tgt, vecs[i].trap, vecs[i].halt);
      step();
      chk_all(i, vecs[i].e_pc, vecs[i].e_v, vecs[i].e_mis, vecs[i].e_halt, vecs[i].e_cnt);
    end

    // Reset issued while in TRAP, with trap_req still held.
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    step();
    chk_all(100, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    step();
    chk_all(101, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'd0);
    // BOOT ignores the trap still requested and moves to RUN.
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    step();
    chk_all(102, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'd0);

    // Misaligned redirect out of HALT: pulse once, TRAP, then valid TRAP_VEC.
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    step();
    chk_all(103, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 32'd0);
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0083, 1'b0, 1'b0);
    step();
    chk_all(104, 32'h0000_0100, 1'b0, 1'b1, 1'b0, 32'd0);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    step();
    chk_all(105, 32'h0000_0100, 1'b1, 1'b0, 1'b0, 32'd0);
    step();
    chk_all(106, 32'h0000_0104, 1'b1, 1'b0, 1'b0, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_pc_unit
